uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Native 8N1 UART transmitter with an internal byte FIFO. It replaces the vendor UART IP's transmit path on the board, and it is the transmit counterpart to the existing receive wrapper. The CPU/echo logic pushes bytes with a one-cycle strobe, and the block serialises them LSB-first on `uart_tx` at a fixed baud rate derived from parameters. It provides back-pressure (`tx_full`), a busy indication and an overflow pulse.

## Interface
Parameters:
- `CLK_HZ`, default 27000000: `sys_clk` frequency in Hz.
- `BAUD`, default 115200: line rate.
- `FIFO_DEPTH`, default 16: byte entries. Must be a power of two, ≥ 2.

Ports:
- `sys_clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `tx_data`  in  8  byte to send. Sampled when `tx_en`=1.
- `tx_en`  in  1  one-cycle push strobe.
- `uart_tx`  out  1  serial line. Idle high.
- `tx_full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `tx_busy`  out  1  FIFO non-empty, or a frame is in progress.
- `tx_ovf`  out  1  one-cycle pulse: a push was dropped.

## Operation
- Bit period: `DIV = (CLK_HZ + BAUD/2) / BAUD` cycles. This is 234 at the defaults. `DIV` ≥ 2 is required, and elaboration fails otherwise.
- Frame: start bit (0), data bits d0..d7 (LSB first), stop bit (1). Each bit is held exactly `DIV` cycles, so a frame is `10*DIV` cycles.
- FIFO write:
  - `tx_en`=1 while `tx_full`=0 stores `tx_data`.
  - `tx_en`=1 while `tx_full`=1 drops the byte and pulses `tx_ovf` on the next cycle.
  - `tx_full` is the registered occupancy, so a push in the same cycle as a pop while full is still dropped.
- State machine (`st`):
  - IDLE: if the FIFO is non-empty, pop the head into `shreg`, clear the bit counter and baud counter, and go to START.
  - START: `uart_tx`=0. After `DIV` cycles, go to DATA.
  - DATA: `uart_tx`=`shreg[0]`. Every `DIV` cycles, shift `shreg` right and increment `bitcnt`. After the 8th bit completes, go to STOP.
  - STOP: `uart_tx`=1. After `DIV` cycles: if the FIFO is non-empty, pop and go directly to START, with no idle gap. Otherwise go to IDLE.
- `uart_tx` is driven from a flop, with no combinational glitch path.
- `tx_busy` = (st != IDLE) | (count != 0).
- Occupancy `count` is `$clog2(FIFO_DEPTH)+1` bits wide. Read and write pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Reset values: `uart_tx`=1, `tx_full`=0, `tx_busy`=0, `tx_ovf`=0. FIFO is emptied, st=IDLE.
- Assertion of `rst_n` mid-frame forces `uart_tx` high immediately and discards the FIFO contents.
- Latency, empty and idle: if `tx_en` is high at edge N, then `tx_busy`=1 after edge N and `uart_tx` falls at edge N+2.
- Pushes made during a frame do not disturb the frame in progress.
- Sustained throughput is one byte per `10*DIV` cycles.
- `tx_full` updates the cycle after the push that fills the FIFO. It falls the cycle after a pop.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_t`.
  - Function `baud_div(clk_hz, baud)`.
  - Constant `UART_DATA_W = 8`.
  - `uart_pkg` is shared with the receive-side logic.
- Sub-module `byte_fifo`:
  - Parameters: `DEPTH`, `WIDTH`.
  - Ports: push, pop, din, dout, full, empty, count. It uses the same clock and reset.
  - Serializer, baud counter and bit counter live in `uart_tx_fifo`.

## Test plan
All scenarios use `CLK_HZ`=1000000, `BAUD`=100000 (`DIV`=10) and `FIFO_DEPTH`=4.
- Reset: hold `rst_n`=0 → `uart_tx`=1, `tx_busy`=0, `tx_full`=0, `tx_ovf`=0.
- Single byte 8'h55: one strobe → `uart_tx` low 2 cycles later. Line sequence is 0,1,0,1,0,1,0,1,0,1, each bit 10 cycles. `tx_busy` falls 100 cycles after the start edge.
- Burst 8'h41,'h42,'h43 on consecutive cycles: three frames back-to-back (300 cycles total, no idle gap) → decoded bytes 41,42,43 in order.
- Overflow: 6 consecutive strobes of 01..06:
  - 01 is popped at once, 02..05 fill the FIFO (`tx_full`=1), and 06 is dropped with one `tx_ovf` pulse.
  - Line outputs 01..05 only.
- Reset mid-frame: assert `rst_n` at cycle 35 of the frame for 8'hA5 → `uart_tx`=1 asynchronously. After release there is no further frame, and `tx_busy`=0.
- Push while full coincident with STOP→START pop: the byte is dropped and `tx_ovf` pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_t;

  // Cycles per bit, rounded to the nearest integer.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte push port and status/line outputs of the UART transmitter.
// Latency: n/a (wiring only).
// Backpressure: producer watches tx_full; pushes while full are dropped.
interface uart_tx_fifo_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] tx_data;
  logic                   tx_en;
  logic                   uart_tx;
  logic                   tx_full;
  logic                   tx_busy;
  logic                   tx_ovf;

  modport master (output tx_data, tx_en,
                  input  uart_tx, tx_full, tx_busy, tx_ovf);

  modport slave  (input  tx_data, tx_en,
                  output uart_tx, tx_full, tx_busy, tx_ovf);
endinterface

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with occupancy count; pointers wrap modulo DEPTH.
// Latency: data written at one edge is visible on dout after that edge.
// Backpressure: push while full and pop while empty are ignored.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("byte_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rptr];

  // Storage array: written on accepted pushes, no reset needed.
  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO; LSB first, idle-high line.
// Latency: push at edge N -> tx_busy after N, start bit on the line at N+2.
// Backpressure: tx_full from registered occupancy; pushes while full drop and pulse tx_ovf.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int BW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: CLK_HZ/BAUD must give at least 2 cycles per bit");
  end

  tx_state_t                   st;
  tx_state_t                   st_nxt;
  logic [UART_DATA_W-1:0]      shreg;
  logic [UART_DATA_W-1:0]      fifo_dout;
  logic [2:0]                  bitcnt;
  logic [BW-1:0]               baud_cnt;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        fifo_pop;
  logic                        load;
  logic                        shift;
  logic                        tick;
  logic                        uart_tx_q;
  logic                        ovf_q;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .push    (bus.tx_en),
    .pop     (fifo_pop),
    .din     (bus.tx_data),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign tick = (baud_cnt == BAUD_LAST);

  // State register plus serializer datapath (shift register, bit and baud counters).
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      shreg    <= '0;
      bitcnt   <= '0;
      baud_cnt <= '0;
    end else begin
      st <= st_nxt;
      if (load)       shreg <= fifo_dout;
      else if (shift) shreg <= shreg >> 1;
      if (load)       bitcnt <= '0;
      else if (shift) bitcnt <= bitcnt + 1'b1;
      if (load || tick || st == ST_IDLE) baud_cnt <= '0;
      else                               baud_cnt <= baud_cnt + 1'b1;
    end
  end

  // Next state and pop/load/shift strobes; STOP chains straight into START when data waits.
  always_comb begin
    st_nxt   = st;
    fifo_pop = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    unique case (st)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          load     = 1'b1;
          st_nxt   = ST_START;
        end
      end
      ST_START: begin
        if (tick) st_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shift = 1'b1;
          if (bitcnt == 3'd7) st_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            load     = 1'b1;
            st_nxt   = ST_START;
          end else begin
            st_nxt = ST_IDLE;
          end
        end
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  // Registered line (one cycle behind st, glitch-free) and the drop pulse.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_tx_q <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      unique case (st)
        ST_START: uart_tx_q <= 1'b0;
        ST_DATA:  uart_tx_q <= shreg[0];
        default:  uart_tx_q <= 1'b1;
      endcase
      ovf_q <= bus.tx_en & fifo_full;
    end
  end

  assign bus.uart_tx = uart_tx_q;
  assign bus.tx_full = fifo_full;
  assign bus.tx_busy = (st != ST_IDLE) | (fifo_count != '0);
  assign bus.tx_ovf  = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo at DIV=10, FIFO_DEPTH=4.
// Line decoder pops expected bytes from a scoreboard; directed checks cover timing edges.
// Pushes are driven #1 after the rising edge; outputs are sampled there too.
module tb_uart_tx_fifo;
  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int DEPTH  = 4;
  localparam int DIV    = 10;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   cyc     = 0;
  bit   mon_en  = 1'b0;
  int   n_vec   = 0;
  int   n_err   = 0;

  logic [7:0] sb[$];
  int         frame_starts[$];

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Strobe one byte for one edge; leaves tx_en low so back-to-back calls give consecutive strobes.
  task automatic drive(input logic [7:0] d);
    bus.tx_data = d;
    bus.tx_en   = 1'b1;
    step();
    bus.tx_en   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.tx_busy !== 1'b0 && n < 2000) begin
      step();
      n++;
    end
    chk(tag, {31'b0, bus.tx_busy}, 32'd0);
    repeat (20) step();
  endtask

  // Reset during a frame of A5 with two more bytes queued behind it.
  task automatic reset_mid(input int offset);
    logic [9:0] fr;
    int lows;
    fr     = {1'b1, 8'hA5, 1'b0};
    mon_en = 1'b0;
    drive(8'hA5);
    drive(8'h11);
    drive(8'h22);
    chk("rst_frame_started", {31'b0, bus.uart_tx}, 32'd0);
    repeat (offset) step();
    chk("rst_pre_line", {31'b0, bus.uart_tx}, {31'b0, fr[offset / DIV]});
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_line", {31'b0, bus.uart_tx}, 32'd1);
    chk("rst_async_busy", {31'b0, bus.tx_busy}, 32'd0);
    chk("rst_async_full", {31'b0, bus.tx_full}, 32'd0);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    lows  = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (bus.uart_tx !== 1'b1) lows++;
    end
    chk("rst_no_frame", lows, 32'd0);
    chk("rst_idle_busy", {31'b0, bus.tx_busy}, 32'd0);
    mon_en = 1'b1;
  endtask

  // Line decoder: sample each bit at its centre, compare against scoreboard head.
  initial begin
    logic [7:0] rx;
    forever begin
      @(negedge sys_clk);
      if (mon_en && rst_n && bus.uart_tx === 1'b0) begin
        frame_starts.push_back(cyc);
        repeat (DIV / 2) @(negedge sys_clk);
        chk("start_bit", {31'b0, bus.uart_tx}, 32'd0);
        for (int j = 0; j < 8; j++) begin
          repeat (DIV) @(negedge sys_clk);
          rx[j] = bus.uart_tx;
        end
        repeat (DIV) @(negedge sys_clk);
        chk("stop_bit", {31'b0, bus.uart_tx}, 32'd1);
        if (sb.size() == 0) chk("spurious_frame", {24'b0, rx}, 32'h100);
        else                chk("rx_byte", {24'b0, rx}, {24'b0, sb.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [9:0] fr;
    logic [7:0] v;
    bus.tx_en   = 1'b0;
    bus.tx_data = '0;

    // Reset values while rst_n is held low.
    repeat (3) step();
    chk("reset_line", {31'b0, bus.uart_tx}, 32'd1);
    chk("reset_busy", {31'b0, bus.tx_busy}, 32'd0);
    chk("reset_full", {31'b0, bus.tx_full}, 32'd0);
    chk("reset_ovf",  {31'b0, bus.tx_ovf},  32'd0);
    @(negedge sys_clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step();

    // Single byte 55: exact per-cycle line shape and busy fall.
    // The line register trails the FSM by one cycle, so busy drops during the last stop-bit cycle.
    fr = {1'b1, 8'h55, 1'b0};
    sb.push_back(8'h55);
    drive(8'h55);
    chk("lat_busy_n", {31'b0, bus.tx_busy}, 32'd1);
    chk("lat_line_n", {31'b0, bus.uart_tx}, 32'd1);
    step();
    chk("lat_line_n1", {31'b0, bus.uart_tx}, 32'd1);
    step();
    for (int i = 0; i < 10 * DIV; i++) begin
      chk("line55", {31'b0, bus.uart_tx}, {31'b0, fr[i / DIV]});
      chk("busy55", {31'b0, bus.tx_busy}, (i < 10 * DIV - 1) ? 32'd1 : 32'd0);
      step();
    end
    wait_idle("single_drain");

    // Burst of three: back-to-back frames 100 cycles apart.
    frame_starts.delete();
    for (int k = 0; k < 3; k++) begin
      v = 8'h41 + 8'(k);
      sb.push_back(v);
      drive(v);
    end
    wait_idle("burst_drain");
    chk("burst_frames", frame_starts.size(), 32'd3);
    if (frame_starts.size() == 3) begin
      chk("burst_gap1", frame_starts[1] - frame_starts[0], 10 * DIV);
      chk("burst_gap2", frame_starts[2] - frame_starts[1], 10 * DIV);
    end

    // Overflow: 01 goes straight to the serializer, 02..05 fill, 06 dropped.
    for (int k = 0; k < 6; k++) begin
      v = 8'(k + 1);
      if (k < 5) sb.push_back(v);
      drive(v);
      chk("ovf_full",  {31'b0, bus.tx_full}, (k >= 4) ? 32'd1 : 32'd0);
      chk("ovf_pulse", {31'b0, bus.tx_ovf},  (k == 5) ? 32'd1 : 32'd0);
    end
    step();
    chk("ovf_pulse_end", {31'b0, bus.tx_ovf}, 32'd0);
    wait_idle("ovf_drain");

    // Push while full on the same edge that STOP pops the next byte.
    for (int k = 0; k < 5; k++) begin
      v = 8'hB1 + 8'(k);
      sb.push_back(v);
      drive(v);
    end
    repeat (10 * DIV - 4) step();
    chk("coin_full_before", {31'b0, bus.tx_full}, 32'd1);
    drive(8'hB6);
    chk("coin_ovf",       {31'b0, bus.tx_ovf},  32'd1);
    chk("coin_full_fall", {31'b0, bus.tx_full}, 32'd0);
    chk("coin_stop_line", {31'b0, bus.uart_tx}, 32'd1);
    step();
    chk("coin_no_gap",  {31'b0, bus.uart_tx}, 32'd0);
    chk("coin_ovf_end", {31'b0, bus.tx_ovf},  32'd0);
    wait_idle("coin_drain");

    // Reset mid-frame: at frame cycle 35 (data bit 2) and inside the start bit.
    reset_mid(35);
    reset_mid(5);

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
